// File: rtl/rv_pkg.sv
// Shared RV front-end definitions: word width, major opcodes, fetch-entry
// record, fetch FSM states and a saturating-add helper for event counters.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_entry_t;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DRAIN
  } fetch_state_t;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Small synchronous FIFO with zero-latency head output, synchronous flush
// and occupancy count. Callers never push into a full FIFO.
module if_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type T = logic [31:0]
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  T                             din,
  input  logic                         pop,
  input  logic                         flush,
  output T                             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  T               mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Qualify push/pop against occupancy and expose the head entry
  always_comb begin
    do_push = push & (count != CW'(DEPTH));
    do_pop  = pop & (count != '0);
    dout    = mem[rd_ptr];
  end

  // Pointer and occupancy bookkeeping; flush empties the queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC, credit-limited in-order imem requests,
// instruction FIFO toward decode, and redirect handling that flushes
// buffered work and discards responses still in flight.
// Optional build macro IF_PERF_CNT_EN adds perf_fetched/perf_dropped counters.
module instr_fetch #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000,
  parameter int unsigned      DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [6:0]      if_opcode
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped
`endif
);

  import rv_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_state_t    state;
  fetch_state_t    state_nxt;
  logic [XLEN-1:0] pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   drop_cnt_nxt;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   tag_count;
  logic [CW:0]     in_use;
  logic [XLEN-1:0] tag_head;
  if_entry_t       push_ent;
  if_entry_t       head_ent;
  logic            fifo_empty;
  logic            req_fire;
  logic            rsp_keep;
  logic            hand;
  logic            unused_bits;

  // Credit, request/response qualification and decode handoff
  always_comb begin
    in_use         = {1'b0, outstanding} + {1'b0, fifo_count};
    imem_req_valid = (state != BOOT) & ~redirect_valid & (in_use < (CW+1)'(DEPTH));
    imem_req_addr  = pc;
    req_fire       = imem_req_valid & imem_req_ready;
    rsp_keep       = imem_rsp_valid & ~redirect_valid & (drop_cnt == '0);
    fifo_empty     = (fifo_count == '0);
    if_valid       = ~fifo_empty & ~redirect_valid;
    hand           = if_valid & if_ready;
    push_ent.pc    = tag_head;
    push_ent.instr = imem_rsp_data;
    if_instr       = fifo_empty ? '0 : head_ent.instr;
    if_pc          = fifo_empty ? '0 : head_ent.pc;
    if_opcode      = if_instr[6:0];
    unused_bits    = ^{tag_count, redirect_pc[1:0]};
  end

  // Discard budget: a redirect covers every request in flight except a
  // response landing in the same cycle, which is dropped directly.
  always_comb begin
    drop_cnt_nxt = drop_cnt;
    if (redirect_valid)
      drop_cnt_nxt = outstanding - CW'(imem_rsp_valid);
    else if (imem_rsp_valid && drop_cnt != '0)
      drop_cnt_nxt = drop_cnt - 1'b1;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (drop_cnt_nxt != '0) state_nxt = DRAIN;
      DRAIN:   if (drop_cnt_nxt == '0) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  // PC, in-flight and discard counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      if (redirect_valid) pc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (req_fire)  pc <= pc + XLEN'(4);
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      drop_cnt    <= drop_cnt_nxt;
    end
  end

  // Tag queue pops only for kept responses: tags of discarded requests
  // were already removed by the redirect flush.
  if_fifo #(.DEPTH(DEPTH), .T(logic [XLEN-1:0])) u_tagq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_fire),
    .din   (pc),
    .pop   (rsp_keep),
    .flush (redirect_valid),
    .dout  (tag_head),
    .count (tag_count)
  );

  if_fifo #(.DEPTH(DEPTH), .T(if_entry_t)) u_ififo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_keep),
    .din   (push_ent),
    .pop   (hand),
    .flush (redirect_valid),
    .dout  (head_ent),
    .count (fifo_count)
  );

`ifdef IF_PERF_CNT_EN
  logic        rsp_drop;
  logic [31:0] drop_inc;

  // Discarded responses plus entries thrown away by a flush
  always_comb begin
    rsp_drop = imem_rsp_valid & ~rsp_keep;
    drop_inc = 32'(rsp_drop) + (redirect_valid ? 32'(fifo_count) : 32'd0);
  end

  // Saturating event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      perf_fetched <= sat_add(perf_fetched, 32'(hand));
      perf_dropped <= sat_add(perf_dropped, drop_inc);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch with an in-order imem model of
// programmable latency. Build with IF_PERF_CNT_EN to also check counters.
module tb_instr_fetch;
  import rv_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [6:0]  if_opcode;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
`endif

  always #5 clk = ~clk;

  instr_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_opcode      (if_opcode)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_dropped   (perf_dropped)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] a0;
    logic [31:0] a1;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          lat = 1;
  int          hand_cnt = 0;
  int          first_valid = -1;
  mreq_t       mq[$];
  logic [31:0] exp_req_addr;
  logic [31:0] exp_pc;
  logic        last_fire;
  logic [31:0] last_fire_addr;
  logic        last_hand;
  logic [31:0] last_hand_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [6:0] op;
    case (a[3:2])
      2'd0:    op = OP_RTYPE;
      2'd1:    op = OP_LOAD;
      2'd2:    op = OP_STORE;
      default: op = OP_BRANCH;
    endcase
    return {a[26:2], op};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic drive_rsp();
    if (mq.size() > 0 && mq[0].due <= cycle) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  // One clock: check the settled outputs, advance, update the imem model
  task automatic cyc();
    logic        fire;
    logic        taken;
    logic [31:0] fa;
    logic [31:0] w;
    #1;
    fire  = imem_req_valid && imem_req_ready;
    fa    = imem_req_addr;
    taken = imem_rsp_valid;
    if (fire) begin
      chk("req_addr", fa, exp_req_addr);
      exp_req_addr = exp_req_addr + 32'd4;
    end
    if (redirect_valid) begin
      chk("redir_req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk("redir_if_valid", {31'b0, if_valid}, 32'd0);
    end
    if (if_valid && first_valid < 0) first_valid = cycle;
    last_hand = if_valid && if_ready;
    last_hand_pc = if_pc;
    if (last_hand) begin
      w = mem_word(exp_pc);
      chk("hand_pc", if_pc, exp_pc);
      chk("hand_instr", if_instr, w);
      chk("hand_opcode", {25'b0, if_opcode}, {25'b0, w[6:0]});
      exp_pc = exp_pc + 32'd4;
      hand_cnt++;
    end
    last_fire = fire;
    last_fire_addr = fa;
    @(posedge clk);
    #1;
    cycle++;
    if (taken) mq.delete(0);
    if (fire) mq.push_back('{addr: fa, due: cycle + lat - 1});
    drive_rsp();
  endtask

  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    mq.delete();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle = 0;
    exp_req_addr = 32'h0;
    exp_pc = 32'h0;
    hand_cnt = 0;
    first_valid = -1;
`ifdef IF_PERF_CNT_EN
    chk("rst_perf_fetched", perf_fetched, 32'd0);
    chk("rst_perf_dropped", perf_dropped, 32'd0);
`endif
    #1;
    chk("boot_no_req", {31'b0, imem_req_valid}, 32'd0);
  endtask

  task automatic do_redirect(input logic [31:0] rpc, input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc = rpc;
    exp_req_addr = target;
    cyc();
    redirect_valid = 1'b0;
    exp_pc = target;
  endtask

  task automatic wait_fire(input string name);
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (last_fire) break;
    end
    if (!last_fire) chk(name, 32'd0, 32'd1);
  endtask

  task automatic wait_hand(input string name, input logic [31:0] pc_exp);
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (last_hand) break;
    end
    chk(name, last_hand ? last_hand_pc : 32'hDEAD_BEEF, pc_exp);
  endtask

  initial begin
    vec_t vecs[4];
    bit   ok;
    int   win_fires;

    vecs[0] = '{rpc: 32'h0000_0103, a0: 32'h0000_0100, a1: 32'h0000_0104};
    vecs[1] = '{rpc: 32'hFFFF_FFFC, a0: 32'hFFFF_FFFC, a1: 32'h0000_0000};
    vecs[2] = '{rpc: 32'hFFFF_FFFF, a0: 32'hFFFF_FFFC, a1: 32'h0000_0000};
    vecs[3] = '{rpc: 32'h0000_0206, a0: 32'h0000_0204, a1: 32'h0000_0208};

    rst_n = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    if_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    exp_req_addr = '0;
    exp_pc = '0;

    // Streaming at 1-cycle latency, then with imem_req_ready toggling
    apply_reset();
    lat = 1;
    for (int i = 0; i < 16; i++) cyc();
    chk("first_valid_ge3", {31'b0, (first_valid >= 3 && first_valid <= 5)}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      imem_req_ready = i[0];
      cyc();
    end
    imem_req_ready = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    chk("stream_handoffs", {31'b0, hand_cnt >= 8}, 32'd1);

    // Decode stalls: credit limit stops requests, head stays put
    if_ready = 1'b0;
    win_fires = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (last_fire) win_fires++;
      chk("stall_pc", if_pc, exp_pc);
      chk("stall_instr", if_instr, mem_word(exp_pc));
    end
    chk("stall_fires_le_depth", {31'b0, win_fires <= DEPTH}, 32'd1);
    chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("stall_if_valid", {31'b0, if_valid}, 32'd1);
    if_ready = 1'b1;
    for (int i = 0; i < 8; i++) cyc();

    // Mid-run reset, then redirect with two requests in flight (latency 3)
    apply_reset();
    lat = 3;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      cyc();
      ok = (mq.size() == 2) && !imem_rsp_valid && !if_valid;
    end
    chk("reach_two_outstanding", {31'b0, ok}, 32'd1);
    do_redirect(32'h0000_0100, 32'h0000_0100);
    wait_hand("redirect_first_pc", 32'h0000_0100);
`ifdef IF_PERF_CNT_EN
    chk("perf_dropped", perf_dropped, 32'd2);
    chk("perf_fetched", perf_fetched, hand_cnt);
`endif

    // Redirect landing on a response and a pending handoff
    lat = 1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      cyc();
      ok = imem_rsp_valid && if_valid;
    end
    chk("reach_rsp_and_hand", {31'b0, ok}, 32'd1);
    do_redirect(32'h0000_0040, 32'h0000_0040);
    wait_hand("coincident_first_pc", 32'h0000_0040);
    for (int i = 0; i < 6; i++) cyc();

    // Redirect target alignment and PC wrap
    foreach (vecs[k]) begin
      do_redirect(vecs[k].rpc, vecs[k].a0);
      wait_fire("vec_fire0");
      chk("vec_addr0", last_fire_addr, vecs[k].a0);
      wait_fire("vec_fire1");
      chk("vec_addr1", last_fire_addr, vecs[k].a1);
      for (int i = 0; i < 4; i++) cyc();
    end
    for (int i = 0; i < 8; i++) cyc();
`ifdef IF_PERF_CNT_EN
    chk("perf_fetched_end", perf_fetched, hand_cnt);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch stage sitting directly upstream of the opcode decoder/control unit.
- Holds the PC and issues in-order word requests to instruction memory.
- Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake; decode consumes if_opcode = if_instr[6:0].
- Handles branch redirects from execute by flushing buffered instructions and discarding in-flight responses.

Parameters:
- XLEN, 32, width of PC and instruction word.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DEPTH, 2, FIFO entries; also the maximum number of outstanding plus buffered fetches (credit limit). Legal range 2..8.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  imem accepts request this cycle.
- imem_req_addr  out  XLEN  word address (PC); bits [1:0] always 0.
- imem_rsp_valid  in  1  response valid; in order; latency ≥1 cycle; never back-pressured.
- imem_rsp_data  in  XLEN  instruction word.
- redirect_valid  in  1  branch taken / PC redirect, single-cycle pulse.
- redirect_pc  in  XLEN  new PC; bits [1:0] ignored (forced 0).
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode accepts.
- if_instr  out  XLEN  instruction word.
- if_pc  out  XLEN  PC of if_instr.
- if_opcode  out  7  if_instr[6:0].

Behaviour:
- Reset (async assert, sync deassert internally):
  - pc = RESET_PC; outstanding = 0; drop_cnt = 0; FIFO empty; state = BOOT.
  - imem_req_valid = 0, if_valid = 0, if_instr = 0, if_pc = 0.
- States:
  - BOOT: one cycle after reset release, no requests; then RUN.
  - RUN: normal operation, drop_cnt = 0.
  - DRAIN: drop_cnt ≠ 0; requests may still issue.
  - RUN→DRAIN on a redirect with nonzero in-flight requests. DRAIN→RUN when drop_cnt reaches 0.
- Credit: imem_req_valid = (state ≠ BOOT) & !redirect_valid & (outstanding + fifo_count < DEPTH).
  - Withdrawal of imem_req_valid on a redirect cycle is permitted by the imem port.
- Request fire (valid & ready): pc += 4 (wraps modulo 2^XLEN); outstanding++.
- Response:
  - If drop_cnt > 0: discard, drop_cnt--, outstanding--.
  - Else push {pc_tag, data} into the FIFO, outstanding--.
  - pc_tag comes from a parallel in-order tag queue of issued addresses, DEPTH entries.
- Decode handoff:
  - if_valid = FIFO non-empty & !redirect_valid; pop on if_valid & if_ready.
  - Outputs are driven from the FIFO head: zero read latency, stable while if_valid & !if_ready.
- Redirect cycle:
  - pc ← {redirect_pc[XLEN-1:2], 2'b00}; FIFO and tag queue flushed.
  - drop_cnt ← outstanding − (rsp arriving this cycle ? 1 : 0). That arriving response is discarded.
  - No request issued, no handoff.
  - First request to the new PC is issued the following cycle at the earliest.
- Simultaneous request fire and response: outstanding unchanged.
- Redirect during DRAIN: drop_cnt recomputed by the same rule (covers all in-flight requests).
- Full credit with if_ready = 0: no requests; PC held.
- Reset mid-operation: everything returns to reset values immediately. Late imem responses are the memory's responsibility (imem is reset by the same rst_n).

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetched (32) and perf_dropped (32).
  - perf_fetched increments on every decode handoff; perf_dropped counts discarded responses plus FIFO entries flushed.
  - Both reset to 0 and saturate at all-ones.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package rv_pkg:
  - XLEN.
  - Opcode constants: OP_RTYPE 7'b0110011, OP_LOAD 7'b0000011, OP_STORE 7'b0100011, OP_BRANCH 7'b1100011.
  - typedef if_entry_t {pc, instr}.
  - Fetch state enum {BOOT, RUN, DRAIN}.
- One sub-module: if_fifo, a parameterised synchronous FIFO (DEPTH, entry type) with push, pop, flush, count.
  - Instantiated for the instruction FIFO.
  - Instantiated again for the address tag queue.

Test Plan:
- Reset release, imem 1-cycle latency, if_ready = 1:
  - imem_req_addr sequence 0x0, 0x4, 0x8…
  - First if_valid no earlier than cycle 3; if_pc/if_instr pairs match memory; if_opcode = instr[6:0].
- if_ready = 0 for 10 cycles:
  - At most DEPTH = 2 requests issued, then imem_req_valid = 0.
  - if_instr stable; resumes in order after if_ready = 1.
- Redirect to 0x100 with 2 requests outstanding (3-cycle latency):
  - Both stale responses dropped; next if_pc = 0x100; no stale instruction reaches decode.
- Redirect coinciding with a response and a pending handoff:
  - No handoff that cycle; drop_cnt excludes the coincident response; if_pc after = redirect target.
- redirect_pc = 0x103:
  - imem_req_addr = 0x100.
- PC near 0xFFFF_FFFC:
  - Next address wraps to 0x0.
- With IF_PERF_CNT_EN:
  - After the redirect scenario, perf_dropped = 2 and perf_fetched equals the number of handoffs.
